// File: rtl/alarm_pkg.sv
// Shared types, mode encodings and BCD validity check for the alarm comparator.
package alarm_pkg;

    typedef logic [15:0] bcd_time_t;

    localparam logic [1:0] MODE_ARMED   = 2'b00;
    localparam logic [1:0] MODE_OFF     = 2'b01;
    localparam logic [1:0] MODE_DISMISS = 2'b10;
    localparam logic [1:0] MODE_SET     = 2'b11;

    // HH 00-23, MM 00-59, every nibble a decimal digit.
    function automatic logic bcd_valid(input bcd_time_t t);
        logic hr_ok;
        logic min_ok;
        hr_ok  = (t[15:12] <  4'd2 && t[11:8] <= 4'd9) ||
                 (t[15:12] == 4'd2 && t[11:8] <= 4'd3);
        min_ok = (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
        return hr_ok && min_ok;
    endfunction

endpackage

// File: rtl/alarm_bcd_time_add.sv
// bcd_time_add: adds a constant minute count to a BCD HH:MM value, wrapping at 24h.
// Compiled only with ALARM_SNOOZE_EN, the only configuration that uses it.
`ifdef ALARM_SNOOZE_EN
module bcd_time_add
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = 5
) (
    input  bcd_time_t t_i,
    output bcd_time_t t_o
);
    logic [6:0] min_sum;
    logic [6:0] min_wrap;
    logic [4:0] hr_sum;
    logic [4:0] hr_wrap;
    logic       carry;

    // Work in binary minutes/hours, then split back into decimal digits.
    always_comb begin
        min_sum  = 7'(t_i[7:4]) * 7'd10 + 7'(t_i[3:0]) + 7'(ADD_MIN);
        carry    = (min_sum >= 7'd60);
        min_wrap = carry ? (min_sum - 7'd60) : min_sum;
        hr_sum   = 5'(t_i[15:12]) * 5'd10 + 5'(t_i[11:8]) + 5'(carry);
        hr_wrap  = (hr_sum >= 5'd24) ? 5'd0 : hr_sum;
        t_o      = {4'(hr_wrap / 5'd10), 4'(hr_wrap % 5'd10),
                    4'(min_wrap / 7'd10), 4'(min_wrap % 7'd10)};
    end
endmodule
`endif

// File: rtl/alarm.sv
// alarm: stored BCD alarm time compared against the running clock; rings for RING_CYCLES.
// Optional ALARM_SNOOZE_EN: mode 10 while ringing advances the alarm by SNOOZE_MIN minutes.
module alarm
    import alarm_pkg::*;
#(
    parameter int RING_CYCLES = 32,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  alarm_mode,
    input  logic [15:0] in_time,
    input  logic [15:0] set_time,
    output logic        ring
);
    localparam int            CW        = $clog2(RING_CYCLES + 1);
    localparam logic [CW-1:0] RING_LOAD = CW'(RING_CYCLES);

    if (RING_CYCLES < 1 || RING_CYCLES > 65535) begin : g_bad_ring
        $error("alarm: RING_CYCLES out of range");
    end
    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze
        $error("alarm: SNOOZE_MIN out of range");
    end

    bcd_time_t     alarm_q, alarm_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          match_dly_q, match_dly_d;
    logic          match;

`ifdef ALARM_SNOOZE_EN
    bcd_time_t     snooze_time;

    bcd_time_add #(.ADD_MIN(SNOOZE_MIN)) u_snooze (
        .t_i (alarm_q),
        .t_o (snooze_time)
    );
`endif

    assign match = armed_q && (in_time == alarm_q);

    always_comb begin
        alarm_d     = alarm_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        match_dly_d = 1'b0;
        case (alarm_mode)
            MODE_SET: begin
                if (bcd_valid(set_time)) begin
                    alarm_d = set_time;
                    armed_d = 1'b1;
                end
                cnt_d = '0;
            end
            MODE_OFF: begin
                armed_d = 1'b0;
                cnt_d   = '0;
            end
            MODE_DISMISS: begin
`ifdef ALARM_SNOOZE_EN
                if (cnt_q != '0) alarm_d = snooze_time;
`endif
                cnt_d = '0;
            end
            default: begin
                // Edge-detect so a held matching time fires only once.
                match_dly_d = match;
                if (match && !match_dly_q)
                    cnt_d = RING_LOAD;
                else if (cnt_q != '0)
                    cnt_d = cnt_q - CW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_q     <= '0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            match_dly_q <= 1'b0;
        end else begin
            alarm_q     <= alarm_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            match_dly_q <= match_dly_d;
        end
    end

    assign ring = (cnt_q != '0);

endmodule

// File: tb/tb_alarm.sv
// Directed bench for alarm: minute-of-day reference model checked every cycle plus literal expectations.
module tb_alarm;
    localparam int RC = 32;
    localparam int SM = 5;
    localparam logic [1:0] ARM = 2'b00, OFF = 2'b01, DIS = 2'b10, SET = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = OFF;
    logic [15:0] in_t = 16'h0000;
    logic [15:0] set_t = 16'h0000;
    logic        ring;

    int checks = 0;
    int failures = 0;

    alarm #(.RING_CYCLES(RC), .SNOOZE_MIN(SM)) dut (
        .clk        (clk),
        .rst        (rst),
        .alarm_mode (mode),
        .in_time    (in_t),
        .set_time   (set_t),
        .ring       (ring)
    );

    always #5 clk = ~clk;

    // Reference model: alarm as minute-of-day, ring as cycles remaining.
    logic [15:0] m_alarm = 16'h0000;
    bit          m_armed = 1'b0;
    int          m_left  = 0;
    bit          m_prev  = 1'b0;

    function automatic bit m_valid(input logic [15:0] t);
        int h, m;
        if (t[15:12] > 9 || t[11:8] > 9 || t[7:4] > 9 || t[3:0] > 9) return 1'b0;
        h = int'(t[15:12]) * 10 + int'(t[11:8]);
        m = int'(t[7:4]) * 10 + int'(t[3:0]);
        return (h < 24) && (m < 60);
    endfunction

    function automatic logic [15:0] m_snooze(input logic [15:0] t);
        int mod, h, m;
        mod = ((int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
               int'(t[7:4]) * 10 + int'(t[3:0]) + SM) % 1440;
        h = mod / 60;
        m = mod % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [15:0] a;
        bit          arm, now;
        int          left;
        if (!rst) begin
            m_alarm <= 16'h0000;
            m_armed <= 1'b0;
            m_left  <= 0;
            m_prev  <= 1'b0;
        end else begin
            a = m_alarm; arm = m_armed; left = m_left; now = 1'b0;
            case (mode)
                SET: begin
                    if (m_valid(set_t)) begin a = set_t; arm = 1'b1; end
                    left = 0;
                end
                OFF: begin arm = 1'b0; left = 0; end
                DIS: begin
`ifdef ALARM_SNOOZE_EN
                    if (left > 0) a = m_snooze(a);
`endif
                    left = 0;
                end
                default: begin
                    now = arm && (in_t == a);
                    if (now && !m_prev) left = RC;
                    else if (left > 0) left = left - 1;
                end
            endcase
            m_alarm <= a;
            m_armed <= arm;
            m_left  <= left;
            m_prev  <= now;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (ring !== (m_left > 0)) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t: ring=%0b model=%0b", $time, ring, (m_left > 0));
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: ring=%0b expected=%0b", name, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] md, input logic [15:0] it, input logic [15:0] st);
        @(negedge clk);
        mode = md; in_t = it; set_t = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held: nothing armed, nothing rings.
        repeat (2) @(negedge clk);
        chk("reset_0000", ring, 1'b0);
        in_t = 16'h1200;
        @(negedge clk);
        chk("reset_1200", ring, 1'b0);
        rst = 1'b1;
        step(ARM, 16'h0000, 16'h0000); chk("unarmed_0000", ring, 1'b0);
        step(ARM, 16'h1200, 16'h0000); chk("unarmed_1200", ring, 1'b0);

        // Basic fire and exact ring length.
        step(SET, 16'h0000, 16'h1209);
        for (int t = 1; t <= 8; t++) begin
            step(ARM, 16'h1200 + 16'(t), 16'h0000);
            chk("pre_match", ring, 1'b0);
        end
        step(ARM, 16'h1209, 16'h0000); chk("fire", ring, 1'b1);
        n = 1;
        repeat (40) begin
            step(ARM, 16'h1209, 16'h0000);
            if (ring) n++;
        end
        checks++;
        if (n != RC) begin
            failures++;
            $display("FAIL ring_len: cycles=%0d expected=%0d", n, RC);
        end
        chk("no_retrigger", ring, 1'b0);

        // Invalid SET values are ignored.
        step(SET, 16'h0000, 16'h2460);
        step(SET, 16'h0000, 16'h1275);
        step(ARM, 16'h1200, 16'h0000); chk("invalid_quiet", ring, 1'b0);
        step(ARM, 16'h1209, 16'h0000); chk("invalid_keeps", ring, 1'b1);

        // Dismiss, SET during ring, OFF disarms.
        step(DIS, 16'h1209, 16'h0000); chk("dismiss", ring, 1'b0);
        step(ARM, 16'h1300, 16'h0000); chk("after_dismiss", ring, 1'b0);
        step(SET, 16'h0000, 16'h1209);
        step(ARM, 16'h1209, 16'h0000); chk("rearm_fire", ring, 1'b1);
        step(SET, 16'h1209, 16'h1209); chk("set_clears", ring, 1'b0);
        step(ARM, 16'h1209, 16'h0000); chk("return_armed_match", ring, 1'b1);
        step(OFF, 16'h1209, 16'h0000); chk("off_clears", ring, 1'b0);
        repeat (3) begin
            step(ARM, 16'h1209, 16'h0000); chk("off_disarms", ring, 1'b0);
        end
        step(SET, 16'h0000, 16'h1209);
        step(ARM, 16'h1209, 16'h0000); chk("set_rearms", ring, 1'b1);

        // Retrigger on the edge where the counter would hit zero.
        repeat (30) step(ARM, 16'h1209, 16'h0000);
        step(ARM, 16'h1300, 16'h0000); chk("last_ring_cycle", ring, 1'b1);
        step(ARM, 16'h1209, 16'h0000); chk("same_edge_retrigger", ring, 1'b1);
        step(ARM, 16'h1300, 16'h0000); chk("retrigger_holds", ring, 1'b1);

        // Async reset between edges kills ring and disarms.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", ring, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(ARM, 16'h0000, 16'h0000); chk("reset_no_fire_0000", ring, 1'b0);
        step(ARM, 16'h1209, 16'h0000); chk("reset_no_fire_1209", ring, 1'b0);

`ifdef ALARM_SNOOZE_EN
        // Snooze across midnight: 23:58 + 5 min -> 00:03.
        step(SET, 16'h0000, 16'h2358);
        step(ARM, 16'h2357, 16'h0000);
        step(ARM, 16'h2358, 16'h0000); chk("snooze_ring", ring, 1'b1);
        step(DIS, 16'h2358, 16'h0000); chk("snooze_clears", ring, 1'b0);
        step(ARM, 16'h2358, 16'h0000); chk("snooze_old_time", ring, 1'b0);
        step(ARM, 16'h0002, 16'h0000); chk("snooze_early", ring, 1'b0);
        step(ARM, 16'h0003, 16'h0000); chk("snooze_fire", ring, 1'b1);
        step(OFF, 16'h0003, 16'h0000);
        step(DIS, 16'h0003, 16'h0000); chk("dis_idle_noop", ring, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alarm.md
# alarm

Time-of-day alarm comparator for the digital clock. It stores an alarm time loaded from `set_time` and compares it every cycle against the running clock time `in_time`, both packed BCD HH:MM. When the armed alarm matches, it asserts `ring` for a bounded number of cycles or until dismissed. It sits beside the timekeeping counter and drives the buzzer/LED output stage.

## Interface
- `RING_CYCLES`, default 32: number of clock cycles `ring` stays high after a trigger, unless dismissed earlier; legal range 1..65535.
- `SNOOZE_MIN`, default 5: snooze offset in minutes, legal range 1..59; used only with `ALARM_SNOOZE_EN`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `alarm_mode`  in  2: 00 ARMED, 01 OFF, 10 DISMISS/SNOOZE, 11 SET.
- `in_time`  in  16: current time in BCD, with [15:12] hour tens, [11:8] hour units, [7:4] minute tens and [3:0] minute units.
- `set_time`  in  16: candidate alarm time in the same BCD format.
- `ring`  out  1: alarm active, registered.

## Operation
- **State**
  - `alarm_reg[15:0]`: stored alarm time.
  - `armed`: set once a valid alarm has been loaded.
  - `ring_cnt`: down-counter, width `$clog2(RING_CYCLES+1)`.
  - `match_d`: previous-cycle match flag.
- **Valid BCD:** hours 00–23 and minutes 00–59, with every nibble ≤ 9. The block never sanity-checks `in_time`; it is only compared.
- **SET (11):** if `set_time` is valid, `alarm_reg` ← `set_time` and `armed` ← 1. An invalid `set_time` is ignored, and `alarm_reg` and `armed` keep their values. SET also clears `ring`/`ring_cnt`.
- **OFF (01):** `armed` ← 0, `ring` and `ring_cnt` cleared, `alarm_reg` retained.
- **ARMED (00):**
  - `match = armed && (in_time == alarm_reg)`.
  - Trigger on the rising edge of `match` (`match && !match_d`): `ring_cnt` ← `RING_CYCLES`.
  - An alarm time held constant for many cycles triggers exactly once.
  - While `ring_cnt` > 0, it decrements each cycle.
- **DISMISS (10), macro off:** `ring_cnt` cleared. `armed` stays 1, so the alarm fires again at the next fresh match (next day).
- **`ring`:** equals `(ring_cnt != 0)`, taken from the registered counter state. No combinational path from any input to `ring`.
- **`match_d`:** updated in every mode. In non-ARMED modes it is loaded with 0, so returning to ARMED while the times already match triggers on the next cycle.

## Timing
- **Reset (`rst`=0, async):** `alarm_reg`=16'h0000, `armed`=0, `ring_cnt`=0, `match_d`=0, so `ring`=0. Reset mid-ring kills `ring` immediately.
- **Trigger latency:** `ring` goes high on the clock edge that samples the first matching `in_time`, visible one cycle after `in_time` changes.
- **Ring duration:** exactly `RING_CYCLES` cycles if undisturbed.
- **SET latency:** the new `alarm_reg` is compared from the cycle after the SET edge.
- **Mode changes during ring:** a mode change to 01, 10 or 11 clears `ring` on the next edge.
- **Same-cycle retrigger:** a retrigger on the same edge that `ring_cnt` reaches 0 reloads `RING_CYCLES`.

## Configuration
- **`ALARM_SNOOZE_EN` defined:** mode 10 while `ring` is high is a snooze.
  - `alarm_reg` ← `alarm_reg` + `SNOOZE_MIN` minutes in BCD.
  - Minutes wrap 59→00 with an hour carry; hours wrap 23→00.
  - `ring` is cleared.
  - Mode 10 with `ring` low has no effect.
- **`ALARM_SNOOZE_EN` undefined:** mode 10 only dismisses, as described above. The adder logic is absent.

## Structure
- **`alarm_pkg`:**
  - Mode constants `MODE_ARMED`/`MODE_OFF`/`MODE_DISMISS`/`MODE_SET`.
  - A BCD-time validity function.
  - A 16-bit BCD time typedef.
- **Sub-module `bcd_time_add`:** adds a constant minute count to a BCD HH:MM value with wrap. It is instantiated only under `ALARM_SNOOZE_EN`.

## Test plan
- **Reset, no alarm set:** reset asserted; `in_time`=16'h0000 and 16'h1200 → `ring`=0 throughout, because `armed`=0.
- **Basic fire:** SET 16'h1209 for one cycle, then ARMED, then `in_time` stepping 16'h1201..16'h1209 one per cycle.
  - `ring`=0 through 1208.
  - `ring`=1 from the edge sampling 1209 for 32 cycles while `in_time` holds 1209.
  - Then 0, with no retrigger.
- **Invalid set:** SET 16'h2460, then 16'h1275 → `alarm_reg` keeps the prior 16'h1209; matching 1209 still fires.
- **Dismiss/off:** during ring, mode 10 (macro off) → `ring`=0 next cycle. Mode 01 then ARMED at a matching time → triggers one cycle after re-arm only if `armed` was restored by SET; otherwise `ring` stays 0.
- **Snooze (macro on):** alarm 16'h2358, ring, then mode 10 → `alarm_reg`=16'h0003, `ring`=0. `in_time`=16'h0003 → fires.
- **Async reset mid-ring:** `rst` low between edges → `ring` drops immediately; after release, a match does not fire until a new SET.
